apb_cmd_master: RTL
===================

// Module: apb_cmd_master
// PURPOSE
//   APB3 requester that sits directly upstream of the APB slave and drives its bus.
//   Accepts single read/write commands on a valid/ready port and runs them as APB
//   SETUP/ACCESS transfers, honouring PREADY wait states.
//   Returns read data and error status on a valid/ready response port.
//   A wait-state watchdog aborts a hung transfer.
// PARAMETERS
//   ADDR_W   32  PADDR / cmd_addr width
//   DATA_W   32  PWDATA / PRDATA / data-port width
//   TIMEOUT  16  max ACCESS cycles with PREADY=0 before abort; 0 = watchdog disabled
// PORTS
//   clk          in   1       bus clock; all logic on posedge
//   PRESET       in   1       reset: synchronous, active-low
//   cmd_valid    in   1       command offered
//   cmd_ready    out  1       command accepted when valid&ready
//   cmd_write    in   1       1=write, 0=read
//   cmd_addr     in   ADDR_W  target address
//   cmd_wdata    in   DATA_W  write data
//   rsp_valid    out  1       response available
//   rsp_ready    in   1       response consumed when valid&ready
//   rsp_rdata    out  DATA_W  read data; 0 for writes and timeouts
//   rsp_err      out  1       PSLVERR captured, or timeout
//   rsp_timeout  out  1       transfer aborted by watchdog
//   PADDR        out  ADDR_W  APB address
//   PSEL         out  1       APB select
//   PENABLE      out  1       APB enable
//   PWRITE       out  1       APB direction
//   PWDATA       out  DATA_W  APB write data
//   PREADY       in   1       slave ready
//   PSLVERR      in   1       slave error; valid only with PREADY=1 in ACCESS
//   PRDATA       in   DATA_W  slave read data; valid only with PREADY=1 in ACCESS
// BEHAVIOUR
//   - All outputs are registered. Reset (PRESET=0 at a clock edge) forces:
//     state=IDLE; every output 0; watchdog counter cleared.
//   - Reset mid-transfer: the transfer is dropped at that edge, PSEL/PENABLE go to 0,
//     and no response is produced.
//   - FSM states: IDLE, SETUP, ACCESS, RESP.
//   - IDLE: cmd_ready=1. On cmd_valid, capture cmd_write/cmd_addr/cmd_wdata into
//     PWRITE/PADDR/PWDATA and go to SETUP.
//   - SETUP: exactly one cycle; PSEL=1, PENABLE=0; cmd_ready=0.
//   - ACCESS: PSEL=1, PENABLE=1.
//     - On PREADY=1: capture PRDATA (reads only; writes return 0) and PSLVERR into the
//       response; drop PSEL/PENABLE; go to RESP.
//     - On PREADY=0: increment the wait counter. If TIMEOUT!=0 and the count reaches
//       TIMEOUT: drop PSEL/PENABLE, set rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
//   - RESP: rsp_valid=1 and response fields held stable. On rsp_ready, go to IDLE with
//     rsp_valid=0. rsp_ready is ignored outside RESP.
//   - PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS, and hold
//     their last value in IDLE/RESP.
//   - Latency (accept at edge N, PREADY=1 on first ACCESS cycle):
//     PSEL at N+1, PENABLE at N+2, rsp_valid at N+3. Each wait state adds one cycle.
//   - Minimum command-to-command spacing is 4 cycles; no pipelining, one outstanding.
//   - Wait counter width is $clog2(TIMEOUT+1), minimum 1. It clears on entering ACCESS
//     and cannot wrap: saturation is the abort.
//   - PREADY and the timeout reaching TIMEOUT in the same cycle: PREADY wins, normal
//     completion.
// STRUCTURE
//   - apb_pkg holds: state enum apb_mst_state_e {IDLE,SETUP,ACCESS,RESP}; the
//     apb_cmd_t and apb_rsp_t structs; default ADDR_W/DATA_W localparams.
//   - Single module; the watchdog stays inline (one counter plus compare).
//     No sub-module.
// TESTING
//   - Write, zero wait: cmd wr addr=0x10 data=0xDEADBEEF, PREADY=1
//     -> PSEL@N+1, PENABLE@N+2, rsp_valid@N+3, rsp_err=0, rsp_rdata=0.
//   - Read, 3 wait states: addr=0x24, PRDATA=0x12345678 with PREADY on the 4th ACCESS
//     cycle -> rsp_rdata=0x12345678@N+6; PADDR stable all cycles.
//   - Slave error: read with PSLVERR=1, PREADY=1 -> rsp_err=1, rsp_timeout=0.
//   - Timeout: TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles; rsp_err=1,
//     rsp_timeout=1, PSEL=0.
//   - Backpressure and reset: hold rsp_ready=0 for 5 cycles -> response stable,
//     cmd_ready=0. Then PRESET=0 during ACCESS -> next edge all outputs 0, no rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//   Shared types for the APB3 command master: FSM state encoding, command and
//   response record layouts at the default bus widths, and default widths.
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage : apb_pkg

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//   APB3 requester. Takes one read/write command at a time on a valid/ready
//   port, runs it as an APB SETUP/ACCESS transfer (honouring PREADY wait
//   states) and returns read data / error status on a valid/ready response
//   port. A wait-state watchdog aborts transfers that stall for TIMEOUT
//   ACCESS cycles (TIMEOUT=0 disables it).
//
//   Ports
//     clk, PRESET                  clock, synchronous active-low reset
//     cmd_valid/ready/write/addr/wdata   command channel
//     rsp_valid/ready/rdata/err/timeout  response channel
//     PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB request (all registered)
//     PREADY/PSLVERR/PRDATA              APB completion from the slave
// ---------------------------------------------------------------------------
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit               WD_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Count value on the last permitted wait cycle; the increment there is the abort.
    localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : CNT_MAX;

    apb_mst_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_W{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= {ADDR_W{1'b0}};
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            paddr_q       <= paddr_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        paddr_d       = paddr_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;

        case (state_q)
            IDLE: begin
                // cmd_ready comes up one cycle after reset release, so a
                // command is taken only once the registered ready is visible.
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = {CNT_W{1'b0}};
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    // PREADY wins over a watchdog expiring in the same cycle.
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? {DATA_W{1'b0}} : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    cnt_d         = cnt_q + CNT_ONE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = {DATA_W{1'b0}};
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    // Saturate so a disabled watchdog never wraps the count.
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PADDR       = paddr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;

endmodule : apb_cmd_master
